// File: rtl/ffs_pkg.sv
// Shared constants and width helpers for the find-first-set priority encoder.
package ffs_pkg;

  localparam int FFS_DEFAULT_WIDTH = 64;

  // Index width: at least one bit, even when the vector is a single bit wide.
  function automatic int ffs_idx_w(input int w);
    int c;
    c = $clog2(w);
    return (c < 1) ? 1 : c;
  endfunction

  // Smallest power of two that is not less than w.
  function automatic int ffs_pad_w(input int w);
    int p;
    p = 1;
    while (p < w) p = p << 1;
    return p;
  endfunction

endpackage

// File: rtl/ffs_node.sv
// One merge level of the find-first-set tree: the lower half wins whenever it has a set bit.
module ffs_node #(
  parameter int CW = 1
) (
  input  logic          i_valid_lo,
  input  logic          i_valid_hi,
  input  logic [CW-1:0] i_idx_lo,
  input  logic [CW-1:0] i_idx_hi,
  output logic          o_valid,
  output logic [CW:0]   o_idx
);

  assign o_valid = i_valid_lo | i_valid_hi;
  assign o_idx   = i_valid_lo ? {1'b0, i_idx_lo} : {1'b1, i_idx_hi};

endmodule

// File: rtl/ffs.sv
// Registered find-first-set over WIDTH request bits; bit 0 has the highest priority.
// Define FFS_ONEHOT_EN to add the registered one-hot output port.
module ffs
  import ffs_pkg::*;
#(
  parameter int WIDTH = FFS_DEFAULT_WIDTH,
  parameter int IDX_W = ffs_idx_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] in,
  output logic             valid,
  output logic [IDX_W-1:0] index
`ifdef FFS_ONEHOT_EN
  ,
  output logic [WIDTH-1:0] onehot
`endif
);

  localparam int PAD_W = ffs_pad_w(WIDTH);
  localparam int LVLS  = $clog2(PAD_W);

  logic             w_valid_c;
  logic [IDX_W-1:0] w_index_c;
  logic             r_valid;
  logic [IDX_W-1:0] r_index;

  if (LVLS == 0) begin : g_single
    assign w_valid_c = in[0];
    assign w_index_c = '0;
  end else begin : g_tree
    logic [PAD_W-1:0] w_pad;

    assign w_pad = PAD_W'(in);

    // Level h holds PAD_W >> h nodes, each reporting an h-bit index within its span.
    for (genvar h = 1; h <= LVLS; h++) begin : g_lvl
      localparam int N = PAD_W >> h;
      logic [N-1:0] w_vld;
      logic [h-1:0] w_idx [N];

      for (genvar j = 0; j < N; j++) begin : g_node
        if (h == 1) begin : g_pair
          assign w_vld[j] = w_pad[2*j] | w_pad[2*j+1];
          assign w_idx[j] = ~w_pad[2*j];
        end else begin : g_merge
          ffs_node #(
            .CW (h - 1)
          ) u_node (
            .i_valid_lo (g_lvl[h-1].w_vld[2*j]),
            .i_valid_hi (g_lvl[h-1].w_vld[2*j+1]),
            .i_idx_lo   (g_lvl[h-1].w_idx[2*j]),
            .i_idx_hi   (g_lvl[h-1].w_idx[2*j+1]),
            .o_valid    (w_vld[j]),
            .o_idx      (w_idx[j])
          );
        end
      end
    end

    // An empty vector steers every node to its upper half, so force the index back to 0.
    assign w_valid_c = g_lvl[LVLS].w_vld[0];
    assign w_index_c = w_valid_c ? IDX_W'(g_lvl[LVLS].w_idx[0]) : '0;
  end

  // NOTE: clocked state is written with non-blocking assignments so every flop
  // samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_index <= '0;
    end else if (en) begin
      r_valid <= w_valid_c;
      r_index <= w_index_c;
    end
  end

  assign valid = r_valid;
  assign index = r_index;

`ifdef FFS_ONEHOT_EN
  logic [WIDTH-1:0] w_onehot_c;
  logic [WIDTH-1:0] r_onehot;

  // Two's-complement trick isolates the lowest set bit.
  assign w_onehot_c = in & (~in + WIDTH'(1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_onehot <= '0;
    end else if (en) begin
      r_onehot <= w_onehot_c;
    end
  end

  assign onehot = r_onehot;
`endif

endmodule

// File: tb/tb_ffs.sv
// Directed and random checks of ffs at WIDTH 64, 5 and 1 (onehot checked when FFS_ONEHOT_EN is defined).
module tb_ffs;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [63:0] in64;
  logic [4:0]  in5;
  logic [0:0]  in1;

  logic        valid64, valid5, valid1;
  logic [5:0]  index64;
  logic [2:0]  index5;
  logic [0:0]  index1;
`ifdef FFS_ONEHOT_EN
  logic [63:0] onehot64;
  logic [4:0]  onehot5;
  logic [0:0]  onehot1;
`endif

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state: what each DUT should show after the most recent edge.
  logic        m_v64, m_v5, m_v1;
  logic [5:0]  m_i64;
  logic [2:0]  m_i5;
  logic [63:0] m_o64;
  logic [4:0]  m_o5;
  logic [0:0]  m_o1;

  always #5 clk = ~clk;

  ffs #(.WIDTH(64)) u_dut64 (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .in     (in64),
    .valid  (valid64),
    .index  (index64)
`ifdef FFS_ONEHOT_EN
    ,
    .onehot (onehot64)
`endif
  );

  ffs #(.WIDTH(5)) u_dut5 (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .in     (in5),
    .valid  (valid5),
    .index  (index5)
`ifdef FFS_ONEHOT_EN
    ,
    .onehot (onehot5)
`endif
  );

  ffs #(.WIDTH(1)) u_dut1 (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .in     (in1),
    .valid  (valid1),
    .index  (index1)
`ifdef FFS_ONEHOT_EN
    ,
    .onehot (onehot1)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  function automatic int low_idx(input logic [63:0] v, input int w);
    for (int i = 0; i < w; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // Advance one clock, update the reference with the inputs seen at the edge, then settle.
  task automatic tick();
    int n;
    @(posedge clk);
    if (!rst) begin
      m_v64 = 1'b0; m_i64 = '0; m_o64 = '0;
      m_v5  = 1'b0; m_i5  = '0; m_o5  = '0;
      m_v1  = 1'b0; m_o1  = '0;
    end else if (en) begin
      n = low_idx(in64, 64);
      m_v64 = (n >= 0);
      m_i64 = (n >= 0) ? 6'(n) : 6'd0;
      m_o64 = (n >= 0) ? (64'h1 << n) : 64'h0;
      n = low_idx({59'h0, in5}, 5);
      m_v5 = (n >= 0);
      m_i5 = (n >= 0) ? 3'(n) : 3'd0;
      m_o5 = (n >= 0) ? 5'(5'h1 << n) : 5'h0;
      m_v1 = in1[0];
      m_o1 = in1;
    end
    #1;
  endtask

  task automatic check_model();
    check("rnd64_valid", 64'(valid64), 64'(m_v64));
    check("rnd64_index", 64'(index64), 64'(m_i64));
    check("rnd5_valid",  64'(valid5),  64'(m_v5));
    check("rnd5_index",  64'(index5),  64'(m_i5));
    check("rnd1_valid",  64'(valid1),  64'(m_v1));
    check("rnd1_index",  64'(index1),  64'h0);
`ifdef FFS_ONEHOT_EN
    check("rnd64_onehot", onehot64,      m_o64);
    check("rnd5_onehot",  64'(onehot5),  64'(m_o5));
    check("rnd1_onehot",  64'(onehot1),  64'(m_o1));
`endif
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    logic [63:0] v;
    int          mode;

    // Reset held for two edges with every request bit set.
    rst = 1'b0; en = 1'b1;
    in64 = '1; in5 = 5'h1f; in1 = 1'b1;
    tick();
    tick();
    check("rst_valid64", 64'(valid64), 64'h0);
    check("rst_index64", 64'(index64), 64'h0);
    check("rst_valid5",  64'(valid5),  64'h0);
    check("rst_valid1",  64'(valid1),  64'h0);
`ifdef FFS_ONEHOT_EN
    check("rst_onehot64", onehot64, 64'h0);
`endif

    // Lowest of two set bits wins.
    rst = 1'b1;
    in64 = 64'h0000_0100_0000_0100; in5 = 5'b10000; in1 = 1'b0;
    tick();
    check("prio_valid64", 64'(valid64), 64'h1);
    check("prio_index64", 64'(index64), 64'd8);
    check("w5_top_index", 64'(index5),  64'd4);
    check("w5_top_valid", 64'(valid5),  64'h1);
    check("w1_zero_valid", 64'(valid1), 64'h0);
`ifdef FFS_ONEHOT_EN
    check("prio_onehot64", onehot64, 64'h100);
    check("w5_top_onehot", 64'(onehot5), 64'h10);
`endif

    // Highest position alone.
    in64 = 64'h8000_0000_0000_0000; in5 = 5'b00110; in1 = 1'b1;
    tick();
    check("msb_index64",  64'(index64), 64'd63);
    check("msb_valid64",  64'(valid64), 64'h1);
    check("w5_mid_index", 64'(index5),  64'd1);
    check("w1_one_valid", 64'(valid1),  64'h1);
    check("w1_one_index", 64'(index1),  64'h0);
`ifdef FFS_ONEHOT_EN
    check("msb_onehot64", onehot64, 64'h8000_0000_0000_0000);
    check("w5_mid_onehot", 64'(onehot5), 64'h2);
`endif

    // All ones: bit 0 wins; width-5 empty vector.
    in64 = '1; in5 = 5'b00000; in1 = 1'b0;
    tick();
    check("ones_index64", 64'(index64), 64'd0);
    check("ones_valid64", 64'(valid64), 64'h1);
    check("w5_zero_valid", 64'(valid5), 64'h0);
    check("w5_zero_index", 64'(index5), 64'h0);

    // Empty vector reports index 0 with valid low.
    in64 = '0; in5 = 5'b00001;
    tick();
    check("zero_valid64", 64'(valid64), 64'h0);
    check("zero_index64", 64'(index64), 64'h0);
    check("w5_lsb_index", 64'(index5),  64'd0);
    check("w5_lsb_valid", 64'(valid5),  64'h1);
`ifdef FFS_ONEHOT_EN
    check("zero_onehot64", onehot64, 64'h0);
`endif

    // Capture, then hold with enable low while the input changes.
    in64 = 64'h10;
    tick();
    check("cap_index64", 64'(index64), 64'd4);
    en = 1'b0; in64 = 64'h1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_index64", 64'(index64), 64'd4);
      check("hold_valid64", 64'(valid64), 64'h1);
    end

    // Reset wins over a deasserted enable.
    rst = 1'b0;
    tick();
    check("mrst_index64", 64'(index64), 64'h0);
    check("mrst_valid64", 64'(valid64), 64'h0);

    // First result after release comes from the first enabled edge.
    rst = 1'b1; en = 1'b1; in64 = 64'h0000_0000_0040_0000;
    tick();
    check("rel_index64", 64'(index64), 64'd22);
    check("rel_valid64", 64'(valid64), 64'h1);

    // Random density, enable and reset against the reference model.
    for (int i = 0; i < 10000; i++) begin
      mode = $urandom_range(0, 5);
      case (mode)
        0:       v = rand64();
        1:       v = rand64() & rand64();
        2:       v = rand64() & rand64() & rand64() & rand64();
        3:       v = rand64() & rand64() & rand64() & rand64() & rand64() & rand64();
        4:       v = 64'h1 << $urandom_range(0, 63);
        default: v = 64'h0;
      endcase
      in64 = v;
      v    = rand64();
      in5  = (mode == 5) ? 5'h0 : ((mode >= 2) ? (v[4:0] & v[9:5]) : v[4:0]);
      in1  = v[10];
      en   = ($urandom_range(0, 3) != 0);
      rst  = ($urandom_range(0, 49) != 0);
      tick();
      check_model();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ffs.md
# ffs

Parameterised find-first-set (priority encoder) with a registered output stage. It scans a request vector and reports the index of the lowest-numbered set bit, plus a flag saying whether any bit is set. In the foreground renderer it picks the topmost opaque object each pixel: bit 0 has the highest priority.

## Interface
- `WIDTH`, default 64: request vector width; legal range 1–1024.
- `IDX_W`, default `max(1, $clog2(WIDTH))`: width of the index output. It is derived from `WIDTH`; callers do not override it.
- `clk` input, 1 bit: the single clock; all state changes on its rising edge.
- `rst` input, 1 bit: synchronous, active-low reset.
- `en` input, 1 bit: capture enable; when low, the output registers hold their value.
- `in` input, `WIDTH` bits: request vector; bit 0 has the highest priority.
- `valid` output, 1 bit: registered; high when any bit of the captured `in` was set.
- `index` output, `IDX_W` bits: registered; position of the lowest set bit in the captured `in`.
- `onehot` output, `WIDTH` bits: registered one-hot of the winning bit. This port exists only when `FFS_ONEHOT_EN` is defined.

## Operation
- Combinational core, with `n = min{ i : in[i] = 1 }`:
  - `valid_c` = OR of all bits of `in`.
  - `index_c` = `n` when `valid_c` is high, else 0.
  - `onehot_c` = `in & (~in + 1)`, i.e. only bit `n` set; all zeros when `in` is 0.
- Output registers, evaluated at each rising clock edge in this priority order:
  1. `rst` low: `valid` = 0, `index` = 0, `onehot` = 0.
  2. `rst` high and `en` high: the outputs load `valid_c`, `index_c` and `onehot_c`.
  3. `rst` high and `en` low: the outputs hold their previous value.
- No-bit-set case: `index` = 0 while `valid` = 0. Consumers must qualify `index` with `valid`.
- `WIDTH` not a power of two: the core pads the vector internally with zeros up to the next power of two. `index` never reports a padded position.
- `WIDTH` = 1: `IDX_W` = 1, `index` is always 0, and `valid` equals the captured `in[0]`.
- X or Z bits on `in` are not supported; no defined output is required for them.

## Timing
- Latency is exactly one clock: `in` sampled at edge k appears on the outputs after edge k.
- Throughput is one vector per cycle. There is no handshake beyond `en`.
- Reset takes effect at the first rising edge with `rst` low, including mid-stream; any in-flight result is discarded. The first result after release comes from the `in` sampled at the first edge with `rst` high and `en` high.
- Combinational depth is `log2(WIDTH)` merge levels. The design must close timing at 12.5875 MHz for `WIDTH` = 64.
- All outputs come directly from flops, with no combinational path from `in` to any output.

## Configuration
- `FFS_ONEHOT_EN` defined:
  - the `onehot` port and its register are present, with the same reset and enable behaviour as `index`;
  - `onehot` always equals `1 << index` when `valid` is high.
- `FFS_ONEHOT_EN` undefined:
  - the `onehot` port and its register are absent;
  - `valid` and `index` behave identically.

## Structure
- Shared package `ffs_pkg` contains:
  - constant `FFS_DEFAULT_WIDTH` = 64;
  - function `ffs_idx_w(w)`, which returns `max(1, $clog2(w))`;
  - function `ffs_pad_w(w)`, which returns the next power of two that is at least `w`.
- One sub-module, `ffs_node`, merges two halves, each with its own valid and index:
  - `valid` = `valid_lo | valid_hi`;
  - `index` = `valid_lo ? {0, idx_lo} : {1, idx_hi}`.
- The top level builds a binary tree of `ffs_node` instances with a generate loop over the padded width, then adds the output registers.

## Test plan
- Run all scenarios with `WIDTH` = 64 and `en` = 1, both with and without `FFS_ONEHOT_EN`.
- Reset: `rst` = 0 for 2 cycles with `in` = 64'hFFFF_FFFF_FFFF_FFFF → `valid` = 0, `index` = 0, `onehot` = 0.
- Priority: `in` = 64'h0000_0100_0000_0100 → after 1 cycle, `valid` = 1, `index` = 8, `onehot` = 64'h100.
- Extremes:
  - `in` = 64'h8000_0000_0000_0000 → `index` = 63.
  - `in` = all ones → `index` = 0.
  - `in` = 0 → `valid` = 0, `index` = 0.
- Hold and reset mid-stream:
  - capture 64'h10 (`index` = 4);
  - drive `en` = 0 and `in` = 64'h1 for 3 cycles → `index` stays 4;
  - drive `rst` = 0 for one edge → next cycle `index` = 0, `valid` = 0.
- Odd width, `WIDTH` = 5:
  - `in` = 5'b10000 → `index` = 4;
  - `in` = 5'b00110 → `index` = 1.
- Random: 10,000 random vectors with random density, plus random `en` and `rst`, checked each cycle against a one-cycle-delayed reference loop (lowest set bit).
